// File: rtl/echo_delay_ctrl_pkg.sv
// rtl/echo_delay_ctrl_pkg.sv - shared types and default widths for the echo/delay engine
//
// Purpose : FSM state encoding and default parameter values used by
//           echo_delay_ctrl and its mixing sub-module.
// Ports   : none (package).

package echo_delay_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 10;
    localparam int DEF_GAIN_WIDTH = 8;

    // One accepted sample walks IDLE -> RD -> MIX -> OUT -> IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_MIX  = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

endpackage

// File: rtl/echo_delay_ctrl_sat_mix.sv
// rtl/echo_delay_ctrl_sat_mix.sv - combinational echo mixer: y = sat(x + (p*g) >>> GW)
//
// Purpose : scales the delayed sample by an unsigned Q0.GW gain and adds it
//           to the dry sample, clipping to the signed DW-bit range.
// Ports   : x_i  dry sample (signed DW)
//           p_i  delayed sample (signed DW)
//           g_i  gain (unsigned GW, value g/2**GW)
//           y_o  mixed, saturated sample (signed DW)

module echo_sat_mix
    import echo_delay_ctrl_pkg::*;
#(
    parameter int DW = DEF_DATA_WIDTH,
    parameter int GW = DEF_GAIN_WIDTH
) (
    input  logic signed [DW-1:0] x_i,
    input  logic signed [DW-1:0] p_i,
    input  logic        [GW-1:0] g_i,
    output logic signed [DW-1:0] y_o
);

    localparam int PW = DW + GW + 1;

    // Clip bounds expressed at full product width so the compare is exact.
    localparam logic signed [PW-1:0] SAT_MAX_W = {{(GW + 2){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN_W = {{(GW + 2){1'b1}}, {(DW - 1){1'b0}}};
    localparam logic        [DW-1:0] SAT_MAX   = {1'b0, {(DW - 1){1'b1}}};
    localparam logic        [DW-1:0] SAT_MIN   = {1'b1, {(DW - 1){1'b0}}};

    logic signed [PW-1:0] p_ext;
    logic signed [PW-1:0] g_ext;
    logic signed [PW-1:0] x_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] scaled;
    logic signed [PW-1:0] sum;

    always_comb begin
        p_ext  = {{(GW + 1){p_i[DW-1]}}, p_i};
        // Gain is unsigned: zero-extend so it multiplies as a positive value.
        g_ext  = {{(DW + 1){1'b0}}, g_i};
        x_ext  = {{(GW + 1){x_i[DW-1]}}, x_i};
        prod   = p_ext * g_ext;
        // Arithmetic shift floors toward -inf for negative echoes.
        scaled = prod >>> GW;
        // |scaled| < 2**(DW-1), so the sum cannot overflow at this width.
        sum    = x_ext + scaled;
        if (sum > SAT_MAX_W) begin
            y_o = SAT_MAX;
        end else if (sum < SAT_MIN_W) begin
            y_o = SAT_MIN;
        end else begin
            y_o = sum[DW-1:0];
        end
    end

endmodule

// File: rtl/echo_delay_ctrl.sv
// rtl/echo_delay_ctrl.sv - circular-buffer echo/delay engine in front of a 1-cycle-latency DPRAM
//
// Purpose : accepts signed samples, stores them (or the mixed output when
//           FEEDBACK=1) in a circular buffer, reads back the sample cfg_delay
//           samples earlier and emits dry + gain*delayed.
// Ports   : clk, rst_n                      clock, async active-low reset
//           s_valid/s_ready/s_data          input sample stream
//           m_valid/m_ready/m_data          mixed output stream
//           cfg_delay, cfg_gain             per-sample delay and echo gain
//           ram_a_addr/ram_a_wr_data/ram_a_wr_en   DPRAM write port
//           ram_b_addr/ram_b_rd_data        DPRAM read port

module echo_delay_ctrl
    import echo_delay_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int GAIN_WIDTH = DEF_GAIN_WIDTH,
    parameter int FEEDBACK   = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic signed [DATA_WIDTH-1:0] s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic signed [DATA_WIDTH-1:0] m_data,
    input  logic        [ADDR_WIDTH-1:0] cfg_delay,
    input  logic        [GAIN_WIDTH-1:0] cfg_gain,
    output logic        [ADDR_WIDTH-1:0] ram_a_addr,
    output logic        [DATA_WIDTH-1:0] ram_a_wr_data,
    output logic                         ram_a_wr_en,
    output logic        [ADDR_WIDTH-1:0] ram_b_addr,
    input  logic        [DATA_WIDTH-1:0] ram_b_rd_data
);

    state_e                       state_q;
    state_e                       state_d;
    logic                         init_q;
    logic        [ADDR_WIDTH-1:0] wr_ptr_q;
    logic        [ADDR_WIDTH-1:0] fill_cnt_q;
    logic signed [DATA_WIDTH-1:0] x_q;
    logic        [ADDR_WIDTH-1:0] d_q;
    logic        [GAIN_WIDTH-1:0] g_q;
    logic        [ADDR_WIDTH-1:0] rd_addr_q;
    logic signed [DATA_WIDTH-1:0] m_data_q;

    logic                         accept;
    logic                         use_delay;
    logic signed [DATA_WIDTH-1:0] p_term;
    logic signed [DATA_WIDTH-1:0] mix_y;

    assign accept = s_valid && s_ready;

    // Delayed term is only taken once the buffer holds at least d samples,
    // so stale RAM contents (power-up or pre-reset) never reach the output.
    assign use_delay = (d_q != '0) && (fill_cnt_q >= d_q);
    assign p_term    = use_delay ? $signed(ram_b_rd_data) : '0;

    echo_sat_mix #(
        .DW (DATA_WIDTH),
        .GW (GAIN_WIDTH)
    ) u_sat_mix (
        .x_i (x_q),
        .p_i (p_term),
        .g_i (g_q),
        .y_o (mix_y)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept)  state_d = ST_RD;
            ST_RD:                state_d = ST_MIX;
            ST_MIX:               state_d = ST_OUT;
            ST_OUT:  if (m_ready) state_d = ST_IDLE;
            default:              state_d = ST_IDLE;
        endcase
    end

    // Output decode; init_q holds s_ready low until the first clock after reset.
    always_comb begin
        s_ready     = (state_q == ST_IDLE) && init_q;
        m_valid     = (state_q == ST_OUT);
        ram_a_wr_en = (state_q == ST_MIX);
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q     <= 1'b0;
            wr_ptr_q   <= '0;
            fill_cnt_q <= '0;
            x_q        <= '0;
            d_q        <= '0;
            g_q        <= '0;
            rd_addr_q  <= '0;
            m_data_q   <= '0;
        end else begin
            init_q <= 1'b1;
            if (accept) begin
                x_q       <= s_data;
                d_q       <= cfg_delay;
                g_q       <= cfg_gain;
                // Modular subtraction wraps naturally across the buffer end.
                rd_addr_q <= wr_ptr_q - cfg_delay;
            end
            if (state_q == ST_MIX) begin
                m_data_q <= mix_y;
                wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
                if (fill_cnt_q != '1) begin
                    fill_cnt_q <= fill_cnt_q + ADDR_WIDTH'(1);
                end
            end
        end
    end

    assign m_data        = m_data_q;
    assign ram_a_addr    = wr_ptr_q;
    assign ram_a_wr_data = (FEEDBACK != 0) ? mix_y : x_q;
    assign ram_b_addr    = rd_addr_q;

endmodule
